// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: PCSrc encodings,
// fetch FSM states and the default reset PC.
package fetch_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;
   localparam logic [1:0] PCSRC_RSV = 2'b11;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DROP  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   // The reserved encoding behaves like sequential flow, so only BR and JMP redirect.
   function automatic logic is_redirect(input logic [1:0] pc_src);
      return !((pc_src == PCSRC_SEQ) || (pc_src == PCSRC_RSV));
   endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Holding register for a fetched instruction and its PC+increment while the
// hazard unit stalls the fetch stage.
module fetch_hold_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] instr_d,
   input  logic [ADDR_W-1:0] pcp1_d,
   output logic [DATA_W-1:0] instr_q,
   output logic [ADDR_W-1:0] pcp1_q
);

   // Capture the instruction/PC pair only when loaded; cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
         pcp1_q  <= '0;
      end else if (load) begin
         instr_q <= instr_d;
         pcp1_q  <= pcp1_d;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the instruction-memory
// request handshake, squashes in-flight fetches on redirect and buffers an
// instruction while the decode stage is stalled.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
   parameter int unsigned        PC_INC   = 1
) (
   input  logic              CLK,
   input  logic              CLR_N,
   input  logic              StallF,
   input  logic [1:0]        PCSrc,
   input  logic [ADDR_W-1:0] PCBranch,
   input  logic [ADDR_W-1:0] PCJump,
   output logic [ADDR_W-1:0] IMA,
   output logic              IMReq,
   input  logic              IMAck,
   input  logic [DATA_W-1:0] IMRD,
   output logic [DATA_W-1:0] InstrF,
   output logic [ADDR_W-1:0] PCp1F,
   output logic              ValidF,
   output logic              FetchBusy
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] redirect_target;
   logic              redirect;
   logic              buf_load;
   logic [DATA_W-1:0] buf_instr;
   logic [ADDR_W-1:0] buf_pcp1;

   // Sequential successor wraps naturally at the top of the address space.
   assign pc_inc = pc_q + ADDR_W'(PC_INC);

   // Decode PCSrc into a redirect flag and its target address.
   always_comb begin
      redirect        = is_redirect(PCSrc);
      redirect_target = pc_inc;
      case (PCSrc)
         PCSRC_BR:  redirect_target = PCBranch;
         PCSRC_JMP: redirect_target = PCJump;
         default:   redirect_target = pc_inc;
      endcase
   end

   // Next-state, next-PC and buffer-load decisions; redirect always wins over a stall.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      buf_load    = 1'b0;
      case (state_q)
         FETCH: begin
            if (!IMAck) begin
               if (redirect) begin
                  drop_addr_d = pc_q;
                  pc_d        = redirect_target;
                  state_d     = DROP;
               end
            end else if (redirect) begin
               pc_d = redirect_target;
            end else if (!StallF) begin
               pc_d = pc_inc;
            end else begin
               buf_load = 1'b1;
               state_d  = HOLD;
            end
         end
         DROP: begin
            if (redirect) begin
               pc_d = redirect_target;
            end
            if (IMAck) begin
               state_d = FETCH;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = redirect_target;
               state_d = FETCH;
            end else if (!StallF) begin
               pc_d    = pc_inc;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // FSM, PC and squashed-request address registers.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   fetch_hold_buffer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_hold_buffer (
      .clk     (CLK),
      .rst_n   (CLR_N),
      .load    (buf_load),
      .instr_d (IMRD),
      .pcp1_d  (pc_inc),
      .instr_q (buf_instr),
      .pcp1_q  (buf_pcp1)
   );

   // Memory request and IF/ID outputs; a zero-wait ack must reach IF/ID in the
   // same cycle, so these stay combinational and are forced quiet during reset.
   always_comb begin
      IMReq  = 1'b0;
      IMA    = pc_q;
      ValidF = 1'b0;
      InstrF = '0;
      PCp1F  = '0;
      if (CLR_N) begin
         case (state_q)
            FETCH: begin
               IMReq = 1'b1;
               IMA   = pc_q;
               if (IMAck && !redirect) begin
                  ValidF = 1'b1;
                  InstrF = IMRD;
                  PCp1F  = pc_inc;
               end
            end
            DROP: begin
               IMReq = 1'b1;
               IMA   = drop_addr_q;
            end
            HOLD: begin
               ValidF = 1'b1;
               InstrF = buf_instr;
               PCp1F  = buf_pcp1;
            end
            default: begin
               IMReq = 1'b0;
            end
         endcase
      end
   end

   assign FetchBusy = !ValidF;

endmodule
